// File: rtl/div_pkg.sv
// Shared types and op-decode helpers for the RV32M divide front-end.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10,
    RESP  = 2'b11
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between the EX stage and div_ctrl.
interface div_ctrl_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [N-1:0] in_rs1;
  logic [N-1:0] in_rs2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/div_sign_fix.sv
// Applies RV32M sign rules to the unsigned core quotient/remainder.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  div_op_e      op,
  input  logic         rs1_neg,
  input  logic         rs2_neg,
  input  logic [N-1:0] div_q,
  input  logic [N-1:0] div_r,
  output logic [N-1:0] result
);

  // Remainder follows the dividend sign; quotient is negative when signs differ
  always_comb begin
    result = {N{1'b0}};
    if (is_rem(op)) begin
      result = (is_signed(op) && rs1_neg) ? ({N{1'b0}} - div_r) : div_r;
    end else begin
      result = (is_signed(op) && (rs1_neg ^ rs2_neg)) ? ({N{1'b0}} - div_q) : div_q;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU/REM/REMU front-end around an unsigned multi-cycle divider core.
// Define DIV_EARLY_OUT_EN to bypass the core when |rs1| < |rs2|.
module div_ctrl
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_ctrl_if.slave    bus,
  input  logic         flush,
  output logic         busy,
  output logic         div_en,
  output logic [N-1:0] div_a,
  output logic [N-1:0] div_b,
  input  logic [N-1:0] div_q,
  input  logic [N-1:0] div_r,
  input  logic         div_done
);

  div_state_e   state_r, state_s;
  div_op_e      op_in_s, op_r;
  logic         s1_r, s2_r, neg1_s, neg2_s;
  logic [N-1:0] mag1_s, mag2_s, fix_s, res_s;
  logic [N-1:0] out_result_r, div_a_r, div_b_r;
  logic         accept_s, zero_s, ovf_s, early_s, done_s, launch_s, load_s;
  logic         out_valid_r, div_en_r;

  assign op_in_s      = div_op_e'(bus.in_op);
  assign bus.in_ready = (state_r == IDLE) && !rst && !flush;
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Magnitudes: the most negative value maps onto itself, which is correct as unsigned
  assign neg1_s = is_signed(op_in_s) && bus.in_rs1[N-1];
  assign neg2_s = is_signed(op_in_s) && bus.in_rs2[N-1];
  assign mag1_s = neg1_s ? ({N{1'b0}} - bus.in_rs1) : bus.in_rs1;
  assign mag2_s = neg2_s ? ({N{1'b0}} - bus.in_rs2) : bus.in_rs2;
  assign zero_s = (bus.in_rs2 == {N{1'b0}});
  assign ovf_s  = is_signed(op_in_s) && (bus.in_rs1 == {1'b1, {(N-1){1'b0}}})
                  && (bus.in_rs2 == {N{1'b1}});
`ifdef DIV_EARLY_OUT_EN
  assign early_s = !zero_s && (mag1_s < mag2_s);
`else
  assign early_s = 1'b0;
`endif

  // A level done left over from the previous request is masked during the launch cycle
  assign done_s = div_done && !div_en_r;

  div_sign_fix #(.N(N)) u_sign_fix (
    .op      (op_r),
    .rs1_neg (s1_r),
    .rs2_neg (s2_r),
    .div_q   (div_q),
    .div_r   (div_r),
    .result  (fix_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, result selection and launch decision
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    launch_s = 1'b0;
    res_s    = {N{1'b0}};
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (zero_s) begin
          load_s  = 1'b1;
          res_s   = is_rem(op_in_s) ? bus.in_rs1 : {N{1'b1}};
          state_s = RESP;
        end else if (ovf_s) begin
          load_s  = 1'b1;
          res_s   = is_rem(op_in_s) ? {N{1'b0}} : {1'b1, {(N-1){1'b0}}};
          state_s = RESP;
        end else if (early_s) begin
          load_s  = 1'b1;
          res_s   = is_rem(op_in_s) ? bus.in_rs1 : {N{1'b0}};
          state_s = RESP;
        end else begin
          launch_s = 1'b1;
          state_s  = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_s = done_s ? IDLE : DRAIN;
        end else if (done_s) begin
          load_s  = 1'b1;
          res_s   = fix_s;
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      RESP: begin
        if (flush || bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered outputs and per-request context
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {N{1'b0}};
      div_en_r     <= 1'b0;
      div_a_r      <= {N{1'b0}};
      div_b_r      <= {N{1'b0}};
      op_r         <= DIV;
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
    end else begin
      out_valid_r <= (state_s == RESP);
      div_en_r    <= launch_s;
      if (load_s) begin
        out_result_r <= res_s;
      end
      if (accept_s) begin
        op_r <= op_in_s;
        s1_r <= neg1_s;
        s2_r <= neg2_s;
      end
      if (launch_s) begin
        div_a_r <= mag1_s;
        div_b_r <= mag2_s;
      end
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign div_en         = div_en_r;
  assign div_a          = div_a_r;
  assign div_b          = div_b_r;
  assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a fixed-latency divider core model.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int N   = 32;
  localparam int LAT = 4;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         busy, div_en;
  logic [N-1:0] div_a, div_b;
  logic [N-1:0] div_q = '0;
  logic [N-1:0] div_r = '0;
  logic         div_done = 1'b0;
  logic [N-1:0] core_a = '0;
  logic [N-1:0] core_b = '0;
  int           core_cnt = 0;
  int           en_count = 0;
  int           n_checks = 0;
  int           n_err = 0;

  div_ctrl_if #(.N(N)) bus ();

  div_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .busy     (busy),
    .div_en   (div_en),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_q    (div_q),
    .div_r    (div_r),
    .div_done (div_done)
  );

  always #5 clk = ~clk;

  // Unsigned core model: done rises LAT cycles after the launch pulse and stays high
  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= 0;
      div_done <= 1'b0;
    end else if (div_en) begin
      core_a   <= div_a;
      core_b   <= div_b;
      core_cnt <= LAT;
      div_done <= 1'b0;
      en_count <= en_count + 1;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      div_done <= 1'b1;
      div_q    <= core_a / core_b;
      div_r    <= core_a % core_b;
    end
  end

  task automatic do_accept(input logic [1:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b, output bit ok);
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat counts negedges after the accepting edge; done_idx marks the rising edge of div_done
  task automatic wait_valid(output int lat, output int done_idx, output bit ok);
    bit prev_done = 1'b1;
    lat = -1;
    done_idx = -1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (div_done && !prev_done && done_idx < 0) done_idx = i;
      prev_done = div_done;
      if (bus.out_valid) begin
        lat = i;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_result;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: got valid=%b result=%h expected 0/0", bus.out_valid, bus.out_result);
    end
    n_checks++;
    if (div_en !== 1'b0 || div_a !== 32'h0 || div_b !== 32'h0) begin
      n_err++;
      $display("FAIL reset_core: got en=%b a=%h b=%h expected zeros", div_en, div_a, div_b);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got in_ready=%b busy=%b expected 0/0", bus.in_ready, busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b expected 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_special;
    logic [1:0]   ops [6] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
    logic [N-1:0] as  [6] = '{32'd100, 32'd100, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    logic [N-1:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [N-1:0] exp [6] = '{32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'h0};
    bit ok, vok;
    int lat, didx, e0;
    for (int i = 0; i < 6; i++) begin
      e0 = en_count;
      do_accept(ops[i], as[i], bs[i], ok);
      wait_valid(lat, didx, vok);
      n_checks++;
      if (!(ok && vok) || lat !== 0) begin
        n_err++;
        $display("FAIL special_latency[%0d]: got accept=%b valid=%b lat=%0d expected 1/1/0", i, ok, vok, lat);
      end
      n_checks++;
      if (bus.out_result !== exp[i]) begin
        n_err++;
        $display("FAIL special_result[%0d]: got %h expected %h", i, bus.out_result, exp[i]);
      end
      n_checks++;
      if (en_count !== e0) begin
        n_err++;
        $display("FAIL special_no_launch[%0d]: got %0d div_en pulses expected 0", i, en_count - e0);
      end
      take_result();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL special_handshake[%0d]: got out_valid=%b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_core_ops;
    logic [1:0]   ops [7] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
    logic [N-1:0] as  [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd7, 32'd7, 32'h80000000, 32'd100};
    logic [N-1:0] bs  [7] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'd7};
    logic [N-1:0] ea  [7] = '{32'd7, 32'd7, 32'h80000000, 32'd7, 32'd7, 32'h80000000, 32'd100};
    logic [N-1:0] eb  [7] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7};
    logic [N-1:0] exp [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFD, 32'd1, 32'hC0000000, 32'd2};
    bit ok, vok;
    int lat, didx, e0;
    for (int i = 0; i < 7; i++) begin
      e0 = en_count;
      do_accept(ops[i], as[i], bs[i], ok);
      wait_valid(lat, didx, vok);
      n_checks++;
      if (!(ok && vok) || didx < 0 || lat !== didx + 1) begin
        n_err++;
        $display("FAIL core_latency[%0d]: got accept=%b valid=%b done_at=%0d valid_at=%0d expected valid one cycle after done",
                 i, ok, vok, didx, lat);
      end
      n_checks++;
      if (bus.out_result !== exp[i]) begin
        n_err++;
        $display("FAIL core_result[%0d]: got %h expected %h", i, bus.out_result, exp[i]);
      end
      n_checks++;
      if (en_count !== e0 + 1) begin
        n_err++;
        $display("FAIL core_pulses[%0d]: got %0d div_en pulses expected 1", i, en_count - e0);
      end
      n_checks++;
      if (div_a !== ea[i] || div_b !== eb[i]) begin
        n_err++;
        $display("FAIL core_operands[%0d]: got a=%h b=%h expected a=%h b=%h", i, div_a, div_b, ea[i], eb[i]);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure;
    bit ok, vok;
    int lat, didx;
    do_accept(2'b01, 32'd20, 32'd3, ok);
    wait_valid(lat, didx, vok);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (!vok || bus.out_valid !== 1'b1 || bus.out_result !== 32'd6 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b result=%h in_ready=%b expected 1/00000006/0",
                 i, bus.out_valid, bus.out_result, bus.in_ready);
      end
      @(negedge clk);
    end
    take_result();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush;
    bit ok, vok;
    int lat, didx, e0;
    e0 = en_count;
    do_accept(2'b01, 32'd1000, 32'd7, ok);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drain: got busy=%b out_valid=%b expected 1/0", busy, bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_blocks_accept: got in_ready=%b expected 0 before div_done", bus.in_ready);
    end
    do_accept(2'b01, 32'd20, 32'd3, ok);
    wait_valid(lat, didx, vok);
    n_checks++;
    if (!(ok && vok) || bus.out_result !== 32'd6) begin
      n_err++;
      $display("FAIL flush_next_result: got valid=%b result=%h expected 1/00000006", vok, bus.out_result);
    end
    n_checks++;
    if (en_count !== e0 + 2) begin
      n_err++;
      $display("FAIL flush_pulses: got %0d div_en pulses expected 2", en_count - e0);
    end
    take_result();

    do_accept(2'b01, 32'd9, 32'd3, ok);
    wait_valid(lat, didx, vok);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    n_checks++;
    if (!vok || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_resp: got valid=%b busy=%b in_ready=%b expected 0/0/1", bus.out_valid, busy, bus.in_ready);
    end

    flush = 1'b1;
    bus.in_op = 2'b01;
    bus.in_rs1 = 32'd5;
    bus.in_rs2 = 32'd1;
    bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_ready: got in_ready=%b expected 0", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_accept: got busy=%b out_valid=%b expected 0/0", busy, bus.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_early_out;
    logic [1:0]   ops [3] = '{2'b11, 2'b00, 2'b10};
    logic [N-1:0] as  [3] = '{32'd5, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [N-1:0] bs  [3] = '{32'd9, 32'd5, 32'd5};
    logic [N-1:0] exp [3] = '{32'd5, 32'h0, 32'hFFFFFFFD};
    bit ok, vok;
    int lat, didx, e0, exp_lat;
    for (int i = 0; i < 3; i++) begin
      e0 = en_count;
      do_accept(ops[i], as[i], bs[i], ok);
      wait_valid(lat, didx, vok);
      exp_lat = EARLY ? 0 : didx + 1;
      n_checks++;
      if (!(ok && vok) || lat !== exp_lat) begin
        n_err++;
        $display("FAIL early_latency[%0d]: got lat=%0d expected %0d", i, lat, exp_lat);
      end
      n_checks++;
      if (bus.out_result !== exp[i]) begin
        n_err++;
        $display("FAIL early_result[%0d]: got %h expected %h", i, bus.out_result, exp[i]);
      end
      n_checks++;
      if (en_count - e0 !== (EARLY ? 0 : 1)) begin
        n_err++;
        $display("FAIL early_pulses[%0d]: got %0d expected %0d", i, en_count - e0, EARLY ? 0 : 1);
      end
      take_result();
    end
  endtask

  task automatic test_reset_mid;
    bit ok, vok;
    int lat, didx;
    do_accept(2'b01, 32'd1000, 32'd7, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || div_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b valid=%b en=%b expected 0/0/0", busy, bus.out_valid, div_en);
    end
    rst = 1'b0;
    @(negedge clk);
    do_accept(2'b01, 32'd20, 32'd3, ok);
    wait_valid(lat, didx, vok);
    n_checks++;
    if (!(ok && vok) || bus.out_result !== 32'd6) begin
      n_err++;
      $display("FAIL reset_recover: got valid=%b result=%h expected 1/00000006", vok, bus.out_result);
    end
    take_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_special();
    test_core_ops();
    test_backpressure();
    test_flush();
    test_early_out();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
